spi_slave_frame_ctrl: RTL and testbench
=======================================

Name: spi_slave_frame_ctrl

Overview:
Parametrised SPI slave front end and the next generation of the fixed 10-bit SPI slave in the SPI/RAM wrapper. It runs off the system clock, with SPI bits sampled at posedge clk. It deserialises command+data frames of DATA_W+2 bits onto rx_data/rx_valid and serialises DATA_W-bit read data from the RAM side onto MISO. It adds generic width, a tx_valid wait timeout, and clean abort on early SS_n deassertion.

Parameters:
DATA_W, 8, payload width; frame width W = DATA_W+2 (2 command bits + payload).
TX_TIMEOUT, 16, max cycles to wait for tx_valid after a read-data frame; range 1..255.

Ports:
clk  input  1  system clock, also the SPI bit clock.
rst_n  input  1  asynchronous active-low reset.
SS_n  input  1  slave select, active low.
MOSI  input  1  serial in, MSB first.
tx_valid  input  1  read data valid from RAM side.
tx_data  input  DATA_W  read data from RAM side.
rx_data  output  DATA_W+2  received frame {cmd[1:0], payload}.
rx_valid  output  1  one-cycle strobe, rx_data valid.
MISO  output  1  serial out, MSB first, registered.
frame_err  output  1  one-cycle error strobe (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, rd_addr_seen=0, all counters 0. Applies mid-frame; the first frame after reset release starts only on a fresh SS_n low sample.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
- Edge numbering: E0 is the first posedge with SS_n=0 while in IDLE; this edge moves IDLE->CHK_CMD.
- E1: MOSI is sampled as cmd[1] and is also the first shifted bit.
  - cmd[1]=0 -> WRITE.
  - cmd[1]=1 and rd_addr_seen=0 -> READ_ADD.
  - cmd[1]=1 and rd_addr_seen=1 -> READ_DATA.
- E1..EW: W bits shifted MSB first into an internal shift register. rx_data and the shift register are separate; rx_data changes only on completion.
- At EW: rx_data <= completed word; rx_valid=1 for exactly the cycle after EW.
- Next state after EW: WRITE/READ_ADD -> DONE; READ_DATA -> TX_WAIT.
- rd_addr_seen: set on READ_ADD completion; cleared on READ_DATA completion.
- Command encoding (rx_data[W-1:W-2]): 00 write addr, 01 write data, 10 read addr, 11 read data. The state is chosen from cmd[1] and rd_addr_seen only; cmd[0] is passed through unchecked.
- TX_WAIT:
  - tx_valid is sampled from the edge after EW onward, so the edge where rx_valid is high counts.
  - On the first edge with tx_valid=1: latch tx_data and go to TX_SHIFT; MISO = tx_data[DATA_W-1] after that edge.
  - If TX_TIMEOUT edges pass without tx_valid: go to DONE, MISO stays 0, timeout event raised.
- TX_SHIFT: each following edge drives the next lower bit. The DATA_W bits are held one cycle each. After the last bit, MISO=0 and state -> DONE.
- DONE: MISO=0; waits for SS_n=1, then IDLE. Extra MOSI bits are ignored.
- Abort: SS_n sampled 1 in any state other than IDLE or DONE -> IDLE next edge.
  - MISO=0; no rx_valid.
  - rx_data and rd_addr_seen are unchanged.
  - Abort event raised.
- SS_n high at the exact edge that would be EW: abort wins; no rx_valid.
- tx_valid outside TX_WAIT is ignored. tx_data is sampled only on the accepting edge.
- Back-to-back frames: one SS_n high sample between frames is sufficient.

Optional Feature:
Macro SPI_SLAVE_FRAME_ERR_EN.
- Defined: frame_err pulses 1 for one cycle, the cycle after an abort or a TX_WAIT timeout. Simultaneous events give a single pulse.
- Undefined: frame_err is tied to 0 and no detection logic is built.
- All other behaviour is identical either way.

Test Plan:
1. DATA_W=8, SS_n low, MOSI=00_1010_0101 on E1..E10, then SS_n high -> one-cycle rx_valid after E10, rx_data=10'h0A5; MISO stays 0.
2. Read-addr frame 10_0011_1100 -> rx_data=10'h23C and rd_addr_seen set. Then frame 11_xxxxxxxx with tx_valid=1, tx_data=8'hC3 on the rx_valid cycle -> MISO=1,1,0,0,0,0,1,1 on successive cycles, then 0; rd_addr_seen cleared.
3. SS_n raised after 5 payload bits of a write frame -> no rx_valid, rx_data keeps its previous value, state IDLE. With SPI_SLAVE_FRAME_ERR_EN, a single frame_err pulse.
4. Read-data frame with tx_valid held 0, TX_TIMEOUT=16 -> after 16 edges state DONE, MISO=0 throughout. frame_err pulses only if the macro is defined.
5. rst_n asserted mid-frame on the 6th bit and mid-TX_SHIFT -> MISO, rx_data, rx_valid all 0 immediately. The next full frame decodes correctly, with read-address routing because rd_addr_seen=0.
6. DATA_W=16: W=18-bit frame 01 followed by 16'hBEEF -> rx_data=18'h1BEEF, rx_valid one cycle after E18.

Source files
------------

// File: rtl/spi_slave_frame_ctrl_if.sv
// SPI slave frame controller bus: serial pins plus the RAM-side
// read-data handshake and the received-frame outputs.
interface spi_slave_frame_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic              MISO;
  logic              frame_err;

  modport slave (
    input  SS_n, MOSI, tx_valid, tx_data,
    output rx_data, rx_valid, MISO, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_valid, tx_data,
    input  rx_data, rx_valid, MISO, frame_err
  );
endinterface

// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave front end running on the system clock. Deserialises
// {cmd[1:0], payload} frames and serialises RAM read data onto MISO.
// Optional macro SPI_SLAVE_FRAME_ERR_EN builds the frame_err strobe
// (abort or tx_valid timeout); without it frame_err is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for SS_n low
// CHK_CMD   | next edge samples cmd[1] (first frame bit), picks route
// WRITE     | shifting a write-address / write-data frame
// READ_ADD  | shifting a read-address frame
// READ_DATA | shifting a read-data frame, then serve tx data
// TX_WAIT   | waiting for tx_valid, bounded by TX_TIMEOUT edges
// TX_SHIFT  | driving latched read data MSB first on MISO
// DONE      | frame finished, ignore MOSI until SS_n high
module spi_slave_frame_ctrl #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  spi_slave_frame_ctrl_if.slave bus
);
  localparam int W     = DATA_W + 2;
  localparam int CNT_W = ($clog2(W) > 8) ? $clog2(W) : 8;

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [W-2:0]      shift_q, shift_d;
  logic [W-1:0]      rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              seen_q, seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] tx_sr_q, tx_sr_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic              err_q, err_d;
`endif

  // Next-state and datapath decode; abort takes priority over everything
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
    seen_d     = seen_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    err_d      = 1'b0;
`endif
    if (state_q != IDLE && state_q != DONE && bus.SS_n) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      cnt_d   = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      err_d   = 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          cnt_d  = '0;
          if (!bus.SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          shift_d = {shift_q[W-3:0], bus.MOSI};
          cnt_d   = CNT_W'(1);
          if (!bus.MOSI)   state_d = WRITE;
          else if (seen_q) state_d = READ_DATA;
          else             state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          shift_d = {shift_q[W-3:0], bus.MOSI};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(W - 1)) begin
            rx_data_d  = {shift_q, bus.MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) seen_d = 1'b1;
            if (state_q == READ_DATA) begin
              seen_d  = 1'b0;
              cnt_d   = CNT_W'(TX_TIMEOUT - 1);
              state_d = TX_WAIT;
            end else begin
              state_d = DONE;
            end
          end
        end
        TX_WAIT: begin
          if (bus.tx_valid) begin
            miso_d  = bus.tx_data[DATA_W-1];
            tx_sr_d = bus.tx_data[DATA_W-2:0];
            cnt_d   = CNT_W'(DATA_W - 1);
            state_d = TX_SHIFT;
          end else if (cnt_q == '0) begin
            state_d = DONE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            err_d   = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        TX_SHIFT: begin
          if (cnt_q == '0) begin
            miso_d  = 1'b0;
            state_d = DONE;
          end else begin
            miso_d  = tx_sr_q[DATA_W-2];
            tx_sr_d = tx_sr_q << 1;
            cnt_d   = cnt_q - 1'b1;
          end
        end
        DONE: begin
          miso_d = 1'b0;
          if (bus.SS_n) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      seen_q     <= 1'b0;
      cnt_q      <= '0;
      tx_sr_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      seen_q     <= seen_d;
      cnt_q      <= cnt_d;
      tx_sr_q    <= tx_sr_d;
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  // Error strobe: one cycle after an abort or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus.frame_err = err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.MISO     = miso_q;
endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Bench for spi_slave_frame_ctrl: a frame-level reference model plans
// each frame as a list of edges (inputs + expected outputs); a driver
// plays the list and pushes expectations; a monitor checks each edge.
module tb_spi_slave_frame_ctrl;
  localparam int DW = 8;
  localparam int W  = DW + 2;
  localparam int T  = 16;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_frame_ctrl_if #(.DATA_W(DW)) bus ();
  spi_slave_frame_ctrl_if #(.DATA_W(16)) bus16 ();

  spi_slave_frame_ctrl #(.DATA_W(DW), .TX_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  spi_slave_frame_ctrl #(.DATA_W(16), .TX_TIMEOUT(T)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16));

  typedef struct {
    logic          ss, mosi, txv;
    logic [DW-1:0] txd;
    logic          miso, err, rxv;
    logic [W-1:0]  rxd;
  } step_t;
  typedef struct {
    int    ed;
    step_t s;
  } exp_t;

  step_t        plan[$];
  exp_t         exp_q[$];
  exp_t         me;
  int           edge_n = 0;
  int           total = 0;
  int           bad = 0;
  logic         m_seen;
  logic [W-1:0] m_rx;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: compare every planned edge's outputs at the following negedge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].ed < edge_n) begin
        me = exp_q.pop_front();
        chk("lost_edge", me.ed, edge_n);
      end
      if (exp_q.size() > 0 && exp_q[0].ed == edge_n) begin
        me = exp_q.pop_front();
        chk("miso", {31'd0, bus.MISO}, {31'd0, me.s.miso});
        chk("frame_err", {31'd0, bus.frame_err}, {31'd0, me.s.err});
        chk("rx_valid", {31'd0, bus.rx_valid}, {31'd0, me.s.rxv});
        chk("rx_data", 32'(bus.rx_data), 32'(me.s.rxd));
      end
    end
  end

  function automatic step_t mk(input logic ss);
    step_t s;
    s.ss   = ss;
    s.mosi = 1'($urandom);
    s.txv  = 1'($urandom);
    s.txd  = DW'($urandom);
    s.miso = 1'b0;
    s.err  = 1'b0;
    s.rxv  = 1'b0;
    s.rxd  = m_rx;
    return s;
  endfunction

  // Reference model: abort_k 1..W aborts during the frame bits, W+j aborts
  // on the j-th edge of the read-data service phase; tx_delay >= T times out.
  task automatic plan_frame(input logic [W-1:0] bits, input int abort_k, input int tx_delay,
                            input logic [DW-1:0] txd, input int done_extra, input int gap);
    step_t s;
    step_t post[$];
    bit    rd_data;
    bit    aborted;
    rd_data = bits[W-1] && m_seen;
    aborted = 1'b0;
    plan.push_back(mk(1'b0));
    for (int k = 1; k <= W && !aborted; k++) begin
      s = mk(1'b0);
      s.mosi = bits[W-k];
      if (k == abort_k) begin
        s.ss = 1'b1; s.err = ERR_ON; aborted = 1'b1;
      end else if (k == W) begin
        m_rx = bits; s.rxv = 1'b1; s.rxd = bits;
        if (bits[W-1]) m_seen = rd_data ? 1'b0 : 1'b1;
      end
      plan.push_back(s);
    end
    if (!aborted && rd_data) begin
      for (int d = 0; d < tx_delay && d < T; d++) begin
        s = mk(1'b0); s.txv = 1'b0;
        if (d == T - 1) s.err = ERR_ON;
        post.push_back(s);
      end
      if (tx_delay < T) begin
        s = mk(1'b0); s.txv = 1'b1; s.txd = txd; s.miso = txd[DW-1];
        post.push_back(s);
        for (int i = DW - 2; i >= 0; i--) begin
          s = mk(1'b0); s.miso = txd[i];
          post.push_back(s);
        end
        post.push_back(mk(1'b0));
      end
      foreach (post[i]) begin
        if (!aborted) begin
          s = post[i];
          if (i + 1 == abort_k - W) begin
            s.ss = 1'b1; s.miso = 1'b0; s.err = ERR_ON; aborted = 1'b1;
          end
          plan.push_back(s);
        end
      end
    end
    if (!aborted) for (int i = 0; i < done_extra; i++) plan.push_back(mk(1'b0));
    for (int i = 0; i < gap; i++) plan.push_back(mk(1'b1));
  endtask

  // Driver: play planned edges (limit < 0 plays all), drop the rest
  task automatic run_plan(input int limit);
    int    n;
    step_t s;
    exp_t  e;
    n = 0;
    while (plan.size() > 0 && (limit < 0 || n < limit)) begin
      s = plan.pop_front();
      bus.SS_n = s.ss; bus.MOSI = s.mosi; bus.tx_valid = s.txv; bus.tx_data = s.txd;
      e.ed = edge_n + 1; e.s = s;
      exp_q.push_back(e);
      @(posedge clk); #1;
      n++;
    end
    plan.delete();
  endtask

  task automatic reset_mid(input int limit);
    run_plan(limit);
    @(negedge clk); #1;
    rst_n = 1'b0; m_seen = 1'b0; m_rx = '0;
    #1;
    chk("rst_miso", {31'd0, bus.MISO}, 32'd0);
    chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    bus.SS_n = 1'b1;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    logic [17:0] v16;
    rst_n = 1'b0;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    bus16.SS_n = 1'b1; bus16.MOSI = 1'b0; bus16.tx_valid = 1'b0; bus16.tx_data = '0;
    m_seen = 1'b0; m_rx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_miso", {31'd0, bus.MISO}, 32'd0);
    chk("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
    chk("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    plan_frame(10'b00_1010_0101, 0, 0, 8'h00, 0, 1);  run_plan(-1);
    plan_frame(10'b10_0011_1100, 0, 0, 8'h00, 1, 1);  run_plan(-1);
    plan_frame(10'b11_0101_1010, 0, 0, 8'hC3, 0, 1);  run_plan(-1);
    plan_frame(10'b01_1111_0000, 8, 0, 8'h00, 0, 2);  run_plan(-1);
    plan_frame(10'b10_0000_0001, 0, 0, 8'h00, 0, 1);  run_plan(-1);
    plan_frame(10'b11_0000_0010, 0, T, 8'hFF, 2, 1);  run_plan(-1);
    plan_frame(10'b00_1100_0011, W, 0, 8'h00, 0, 1);  run_plan(-1);
    plan_frame(10'b10_0000_0100, 0, 0, 8'h00, 0, 1);  run_plan(-1);
    plan_frame(10'b11_0000_1000, W + 4, 0, 8'hA5, 0, 1); run_plan(-1);
    plan_frame(10'b10_0001_0000, 0, 0, 8'h00, 0, 1);  run_plan(-1);
    plan_frame(10'b11_0010_0000, W + T, T + 2, 8'h00, 0, 1); run_plan(-1);

    plan_frame(10'b01_1011_0110, 0, 0, 8'h00, 0, 1);
    reset_mid(7);
    plan_frame(10'b10_1110_0111, 0, 0, 8'h00, 0, 1);
    L = plan.size();
    plan_frame(10'b11_0000_0000, 0, 1, 8'hFF, 0, 1);
    reset_mid(L + 1 + W + 5);
    plan_frame(10'b11_0110_0110, 0, 0, 8'h5A, 0, 1);  run_plan(-1);
    plan_frame(10'b11_1001_1001, 0, 3, 8'h96, 0, 1);  run_plan(-1);

    for (int f = 0; f < 150; f++) begin
      int ak, td;
      ak = (int'($urandom_range(0, 4)) == 0) ? int'($urandom_range(1, W + DW + 1)) : 0;
      td = (int'($urandom_range(0, 5)) == 0) ? int'($urandom_range(T - 2, T + 3))
                                             : int'($urandom_range(0, 4));
      plan_frame(W'($urandom), ak, td, DW'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      run_plan(-1);
    end

    v16 = 18'h1BEEF;
    bus16.SS_n = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 18; k++) begin
      bus16.MOSI = v16[18-k];
      @(posedge clk); #1;
      chk("w16_rx_valid", {31'd0, bus16.rx_valid}, {31'd0, logic'(k == 18)});
    end
    chk("w16_rx_data", 32'(bus16.rx_data), 32'h1BEEF);
    bus16.SS_n = 1'b1;
    @(posedge clk); #1;
    chk("w16_rx_valid_drop", {31'd0, bus16.rx_valid}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
